// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, HALT, FAULT} fetch_state_t;

  localparam logic [31:0] HALT_INST  = 32'h0000_0000;
  localparam int          INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo2.sv
// Two-entry {pc, inst} buffer; the head register drives the outputs directly.
// Accepts a push while full when the head is popped in the same cycle; flush empties it in one edge.
module fetch_fifo2
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         in_vld_i,
  input  fetch_entry_t in_dat_i,
  output logic         in_rdy_o,
  output logic         out_vld_o,
  input  logic         out_rdy_i,
  output fetch_entry_t out_dat_o,
  output logic [1:0]   count_o
);

  logic [1:0]   count_q, count_d;
  fetch_entry_t head_q, head_d;
  fetch_entry_t tail_q, tail_d;
  logic         enq, deq;

  assign out_vld_o = (count_q != 2'd0);
  assign out_dat_o = head_q;
  assign count_o   = count_q;
  assign in_rdy_o  = (count_q != 2'd2) || out_rdy_i;
  assign deq       = out_vld_o && out_rdy_i;
  assign enq       = in_vld_i && in_rdy_o;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush_i) begin
      count_d = 2'd0;
    end else begin
      case ({enq, deq})
        2'b11: begin
          // Pop and push together: tail slides forward when two entries were held.
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = in_dat_i;
          end else begin
            head_d = in_dat_i;
          end
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) head_d = in_dat_i;
          else                 tail_d = in_dat_i;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, reads imem combinationally and queues {pc, inst} for decode.
// Handles redirect/flush, stops at the all-zero word and faults on misaligned or out-of-range PCs.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * INST_BYTES);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         halted_q, fault_q;

  logic         active, redir, redir_bad, start_ok, in_range;
  logic         fetch_en, is_halt, fifo_enq, flush, drain_done;
  logic         fifo_in_rdy;
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_in, fifo_out;

  assign active     = (state_q == RUN) || (state_q == DRAIN);
  assign redir      = redirect_valid && active;
  assign redir_bad  = redir && (redirect_pc[1:0] != 2'b00);
  assign start_ok   = start && !active;
  assign in_range   = pc_q < PC_LIMIT;
  // Redirect outranks fetch, so a word read in a redirect cycle is dropped.
  assign fetch_en   = (state_q == RUN) && fifo_in_rdy && !redir && in_range;
  assign is_halt    = (imem_inst == HALT_INST);
  assign fifo_enq   = fetch_en && !is_halt;
  assign flush      = start_ok || redir;
  assign drain_done = (fifo_count == 2'd0) ||
                      ((fifo_count == 2'd1) && out_valid && out_ready);
  assign fifo_in    = '{pc: pc_q, inst: imem_inst};

  assign imem_addr  = pc_q;
  assign out_pc     = fifo_out.pc;
  assign out_inst   = fifo_out.inst;
  assign halted     = halted_q;
  assign fault      = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (start_ok) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (redir_bad) begin
      state_q  <= FAULT;
      halted_q <= 1'b1;
      fault_q  <= 1'b1;
    end else if (redir) begin
      state_q  <= RUN;
      pc_q     <= redirect_pc;
    end else begin
      case (state_q)
        RUN: begin
          if (!in_range) begin
            state_q  <= FAULT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else if (fetch_en) begin
            // A zero word may be on a wrong path; DRAIN keeps listening for redirects.
            if (is_halt) state_q <= DRAIN;
            else         pc_q    <= pc_q + 32'(INST_BYTES);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fetch_fifo2 u_fifo (
    .clk       (clk),
    .rst       (reset),
    .flush_i   (flush),
    .in_vld_i  (fifo_enq),
    .in_dat_i  (fifo_in),
    .in_rdy_o  (fifo_in_rdy),
    .out_vld_o (out_valid),
    .out_rdy_i (out_ready),
    .out_dat_o (fifo_out),
    .count_o   (fifo_count)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: imem model plus an ordered queue of expected {pc, inst} handshakes.
module tb_fetch_ctrl;

  localparam logic [31:0] I_ADD = 32'h002081b3;
  localparam logic [31:0] I_SUB = 32'h40208233;
  localparam logic [31:0] I_XOR = 32'h0020c2b3;
  localparam logic [31:0] I_W8  = 32'h00500093;
  localparam logic [31:0] I_W9  = 32'h00a00113;

  logic        clk = 1'b0;
  logic        reset, start, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_inst, out_inst, out_pc;
  logic        out_valid, halted, fault;

  logic [31:0] mem [256];
  logic [63:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  assign imem_inst = (imem_addr < 32'h400) ? mem[imem_addr[9:2]] : 32'h0BAD_0001;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc), .halted(halted), .fault(fault)
  );

  // One cycle: scoreboard the handshake at negedge, return 1 time unit after the next posedge.
  task automatic tick();
    logic [63:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h inst=%h, none expected", out_pc, out_inst);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_inst} !== e) begin
          errors++;
          $display("FAIL sb_order got pc=%h inst=%h want pc=%h inst=%h", out_pc, out_inst, e[63:32], e[31:0]);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (halted) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_empty(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (exp_q.size() == 0) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = I_ADD; mem[1] = I_SUB; mem[2] = I_XOR;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL rst_data got %h/%h want 0/0", out_pc, out_inst); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_flags got %b%b want 00", halted, fault); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h want 0", imem_addr); end
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL idle_nofetch got v=%b addr=%h want 0/0", out_valid, imem_addr); end
  endtask

  task automatic test_sequential();
    bit ok;
    load_basic();
    out_ready = 1'b1;
    exp_q.push_back({32'h0, I_ADD}); exp_q.push_back({32'h4, I_SUB}); exp_q.push_back({32'h8, I_XOR});
    do_start();
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL seq_e0 got v=%b addr=%h want 0/0", out_valid, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== I_ADD) begin errors++; $display("FAIL seq_latency got v=%b pc=%h inst=%h want 1/0/%h", out_valid, out_pc, out_inst, I_ADD); end
    tick(); tick(); tick();
    checks++; if (halted !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL seq_drain got h=%b v=%b want 0/0", halted, out_valid); end
    tick();
    checks++; if (halted !== 1'b1 || fault !== 1'b0) begin errors++; $display("FAIL seq_halt got h=%b f=%b want 1/0", halted, fault); end
    wait_empty(5, ok);
    checks++; if (!ok) begin errors++; $display("FAIL seq_all_seen got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    load_basic();
    out_ready = 1'b0;
    do_start();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== I_ADD) begin errors++; $display("FAIL bp_hold cyc=%0d got v=%b pc=%h want 1/0", i, out_valid, out_pc); end
      if (i >= 1) begin
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL bp_pc_stop cyc=%0d got %h want 8", i, imem_addr); end
      end
    end
    exp_q.push_back({32'h0, I_ADD}); exp_q.push_back({32'h4, I_SUB}); exp_q.push_back({32'h8, I_XOR});
    out_ready = 1'b1;
    wait_empty(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_release got %0d left want 0", exp_q.size()); end
    wait_halted(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_halt got halted=%b want 1", halted); end
  endtask

  task automatic test_redirect();
    bit ok;
    load_basic();
    mem[8] = I_W8; mem[9] = I_W9;
    out_ready = 1'b0;
    do_start();
    tick(); tick();
    exp_q.push_back({32'h0, I_ADD});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_pc !== 32'h4 || imem_addr !== 32'hc) begin errors++; $display("FAIL rd_setup got pc=%h addr=%h want 4/c", out_pc, imem_addr); end
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h20) begin errors++; $display("FAIL rd_bubble got v=%b addr=%h want 0/20", out_valid, imem_addr); end
    exp_q.push_back({32'h20, I_W8}); exp_q.push_back({32'h24, I_W9});
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h20) begin errors++; $display("FAIL rd_target got v=%b pc=%h want 1/20", out_valid, out_pc); end
    wait_empty(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_all_seen got %0d left want 0", exp_q.size()); end
    wait_halted(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rd_halt got halted=%b want 1", halted); end
  endtask

  task automatic test_drain_redirect();
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = I_ADD; mem[1] = I_SUB; mem[4] = I_XOR;
    out_ready = 1'b0;
    do_start();
    tick(); tick();
    exp_q.push_back({32'h0, I_ADD});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (out_pc !== 32'h4 || imem_addr !== 32'h8 || halted !== 1'b0) begin errors++; $display("FAIL dr_in_drain got pc=%h addr=%h h=%b want 4/8/0", out_pc, imem_addr, halted); end
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h10 || halted !== 1'b0) begin errors++; $display("FAIL dr_redirect got v=%b addr=%h h=%b want 0/10/0", out_valid, imem_addr, halted); end
    exp_q.push_back({32'h10, I_XOR});
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || halted !== 1'b0) begin errors++; $display("FAIL dr_resume got v=%b pc=%h h=%b want 1/10/0", out_valid, out_pc, halted); end
    wait_empty(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dr_all_seen got %0d left want 0", exp_q.size()); end
    wait_halted(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL dr_halt got halted=%b want 1", halted); end
  endtask

  task automatic test_fault_misaligned();
    load_basic();
    out_ready = 1'b0;
    do_start();
    tick();
    checks++; if (fault !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL mis_pre got f=%b v=%b want 0/1", fault, out_valid); end
    redirect_valid = 1'b1; redirect_pc = 32'h22;
    tick();
    redirect_valid = 1'b0;
    checks++; if (fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_fault got f=%b h=%b v=%b want 1/1/0", fault, halted, out_valid); end
  endtask

  task automatic test_fault_range_and_restart();
    bit ok;
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | 32'(i);
    for (int i = 0; i < 256; i++) exp_q.push_back({32'(i * 4), 32'h1000_0000 | 32'(i)});
    out_ready = 1'b1;
    do_start();
    checks++; if (fault !== 1'b0 || halted !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL restart_clear got f=%b h=%b addr=%h want 0/0/0", fault, halted, imem_addr); end
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (fault) ok = 1'b1;
      else tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL range_fault got fault=%b want 1", fault); end
    checks++; if (halted !== 1'b1 || imem_addr !== 32'h400) begin errors++; $display("FAIL range_state got h=%b addr=%h want 1/400", halted, imem_addr); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL range_all_seen got %0d left want 0", exp_q.size()); end
    out_ready = 1'b0;
    do_start();
    checks++; if (fault !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL range_restart got f=%b addr=%h want 0/0", fault, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h1000_0000) begin errors++; $display("FAIL range_restart_out got v=%b pc=%h inst=%h want 1/0/10000000", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_reset_mid_run();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL mid_rst_out got v=%b pc=%h inst=%h want 0/0/0", out_valid, out_pc, out_inst); end
    checks++; if (halted !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_rst_state got h=%b f=%b addr=%h want 0/0/0", halted, fault, imem_addr); end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || halted !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got v=%b addr=%h h=%b want 0/0/0", out_valid, imem_addr, halted); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    load_basic();
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_drain_redirect();
    test_fault_misaligned();
    test_fault_range_and_restart();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
